// File: rtl/match_event_capture_pkg.sv
// ============================================================================
// Package : match_event_capture_pkg
// Shared widths and FSM encoding for the match event capture stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package match_event_capture_pkg;

  localparam int SEQ_W  = 8;
  localparam int DROP_W = 16;
  localparam int TS_W   = 32;
  localparam int EV_W   = TS_W + SEQ_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/match_event_capture_event_fifo.sv
// ============================================================================
// Module  : event_fifo
// Show-ahead synchronous FIFO with registered count/empty/full flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module event_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic                  do_push, do_pop;

  // A pop frees a slot in the same cycle, so push at full is allowed alongside it.
  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

`default_nettype wire

// File: rtl/match_event_capture.sv
// ============================================================================
// Module  : match_event_capture
// Qualifies match pulses, applies holdoff, and queues timestamped events.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module match_event_capture
  import match_event_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int HOLD_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rxstrobe,
  input  logic                  valid,
  input  logic                  match,
  input  logic [TS_W-1:0]       timestamp,
  input  logic [HOLD_W-1:0]     holdoff,
  input  logic                  rd_en,
  input  logic                  clr_stat,
  output logic [TS_W-1:0]       ev_ts,
  output logic [SEQ_W-1:0]      ev_seq,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   ev_count,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [SEQ_W-1:0]  SEQ_ONE  = SEQ_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                hit, accept, push, drop, pop;
  logic                fifo_full, fifo_empty;
  logic [EV_W-1:0]     fifo_dout;

  assign hit = enable & rxstrobe & valid & match;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (hit) begin
            accept = 1'b1;
            if (holdoff != '0) begin
              hold_d  = holdoff;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (rxstrobe) begin
            hold_d = hold_q - HOLD_ONE;
            if (hold_q == HOLD_ONE) state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A simultaneous read frees the slot the full FIFO needs, so no drop then.
  assign pop  = rd_en;
  assign push = accept & (~fifo_full | rd_en);
  assign drop = accept & fifo_full & ~rd_en;

  always_comb begin
    seq_d      = accept ? seq_q + SEQ_ONE : seq_q;
    overflow_d = clr_stat ? 1'b0 : overflow_q;
    drop_cnt_d = clr_stat ? '0 : drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != DROP_MAX) drop_cnt_d = drop_cnt_d + DROP_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  event_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (EV_W)
  ) u_event_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   ({timestamp, seq_q}),
    .dout  (fifo_dout),
    .count (ev_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ev_ts    = fifo_dout[EV_W-1:SEQ_W];
  assign ev_seq   = fifo_dout[SEQ_W-1:0];
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire
